sat_round_pipe: RTL and testbench

Multi-channel saturating requantizer with rounding, a signed mode and a valid/ready pipeline. It is the pipelined successor to the team's combinational/registered flooring block. Each beat carries CH wide samples, and each sample is reduced to OSIZE bits by dropping low bits (floor or round-half-up) and clamping on overflow. The block sits between accumulator/filter outputs and narrower downstream datapaths, and reports saturation per beat and cumulatively.

---
 rtl/sat_round_pkg.sv | 8 +
 rtl/sat_round_lane.sv | 53 +++++
 rtl/sat_round_pipe.sv | 64 ++++++
 tb/tb_sat_round_pipe.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/sat_round_pkg.sv
// sat_round_pkg: shared constants and configuration check for the saturating requantizer
package sat_round_pkg;
   localparam logic RND_FLOOR   = 1'b0;
   localparam logic RND_HALF_UP = 1'b1;
   function automatic bit cfg_ok(input int dsize, input int csize, input int osize);
      return csize < dsize && csize + osize <= dsize;
   endfunction
endpackage

// File: rtl/sat_round_lane.sv
// sat_round_lane: one channel of shift/round (S1) and clamp/sat-flag (S2) datapath
module sat_round_lane
   import sat_round_pkg::*;
#(
   parameter int DSIZE  = 16,
   parameter int CSIZE  = 4,
   parameter int OSIZE  = 8,
   parameter int SIGNED = 0
) (
   input  logic             clock,
   input  logic             rst_n,
   input  logic             s1_en,
   input  logic             s2_en,
   input  logic             rnd,
   input  logic [DSIZE-1:0] din,
   output logic [OSIZE-1:0] dout,
   output logic             sat
);
   localparam int LSIZE = DSIZE - CSIZE - OSIZE;
   localparam int W     = DSIZE + 2;
   localparam int RSH   = LSIZE > 0 ? LSIZE - 1 : 0;
   localparam logic signed [W-1:0] HALF = LSIZE > 0 ? {{(W-1){1'b0}}, 1'b1} << RSH : '0;
   localparam logic signed [W-1:0] HI = SIGNED != 0 ? {{(W-OSIZE+1){1'b0}}, {(OSIZE-1){1'b1}}}
                                                    : {{(W-OSIZE){1'b0}}, {OSIZE{1'b1}}};
   localparam logic signed [W-1:0] LO = SIGNED != 0 ? {{(W-OSIZE+1){1'b1}}, {(OSIZE-1){1'b0}}} : '0;
   logic signed [W-1:0] sum, y_d, y_q;
   logic [OSIZE-1:0] dout_d, dout_q;
   logic sat_d, sat_q;
   // S1: extend with headroom so the rounding carry never wraps, then floor-shift
   always_comb begin
      sum = $signed({{2{SIGNED != 0 && din[DSIZE-1]}}, din}) + (rnd == RND_HALF_UP ? HALF : '0);
      y_d = s1_en ? sum >>> LSIZE : y_q;
   end
   // S2: clamp to the output range and flag any clamping
   always_comb begin
      sat_d  = s2_en ? (y_q > HI || y_q < LO) : sat_q;
      dout_d = !s2_en ? dout_q : y_q > HI ? HI[OSIZE-1:0] : y_q < LO ? LO[OSIZE-1:0] : y_q[OSIZE-1:0];
   end
   // pipeline registers
   always_ff @(posedge clock) begin
      if (!rst_n) begin
         y_q    <= '0;
         dout_q <= '0;
         sat_q  <= 1'b0;
      end else begin
         y_q    <= y_d;
         dout_q <= dout_d;
         sat_q  <= sat_d;
      end
   end
   assign dout = dout_q;
   assign sat  = sat_q;
endmodule

// File: rtl/sat_round_pipe.sv
// sat_round_pipe: multi-channel saturating requantizer with valid/ready pipeline and sat counter
module sat_round_pipe
   import sat_round_pkg::*;
#(
   parameter int DSIZE  = 16,
   parameter int CSIZE  = 4,
   parameter int OSIZE  = 8,
   parameter int CH     = 2,
   parameter int SIGNED = 0,
   parameter int CNT_W  = 16
) (
   input  logic                clock,
   input  logic                rst_n,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [CH*DSIZE-1:0] indata,
   input  logic                rnd_mode,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [CH*OSIZE-1:0] outdata,
   output logic [CH-1:0]       out_sat,
   output logic [CNT_W-1:0]    sat_cnt,
   input  logic                cnt_clr
);
   if (!cfg_ok(DSIZE, CSIZE, OSIZE)) begin : g_bad_cfg
      $error("sat_round_pipe: need CSIZE < DSIZE and CSIZE+OSIZE <= DSIZE");
   end
   logic s1_valid_d, s1_valid_q, out_valid_d, out_valid_q, s2_load;
   logic [CNT_W-1:0] cnt_d, cnt_q;
   // shared stage control and saturating counter (clear beats a same-cycle increment)
   always_comb begin
      s2_load     = !out_valid_q || out_ready;
      in_ready    = !s1_valid_q || s2_load;
      s1_valid_d  = in_ready ? in_valid : s1_valid_q;
      out_valid_d = s2_load ? s1_valid_q : out_valid_q;
      cnt_d       = cnt_clr ? '0 : (out_valid_q && out_ready && |out_sat && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
   end
   // control registers
   always_ff @(posedge clock) begin
      if (!rst_n) begin
         s1_valid_q  <= 1'b0;
         out_valid_q <= 1'b0;
         cnt_q       <= '0;
      end else begin
         s1_valid_q  <= s1_valid_d;
         out_valid_q <= out_valid_d;
         cnt_q       <= cnt_d;
      end
   end
   for (genvar i = 0; i < CH; i++) begin : g_lane
      sat_round_lane #(.DSIZE(DSIZE), .CSIZE(CSIZE), .OSIZE(OSIZE), .SIGNED(SIGNED)) u_lane (
         .clock (clock),
         .rst_n (rst_n),
         .s1_en (in_valid && in_ready),
         .s2_en (s2_load && s1_valid_q),
         .rnd   (rnd_mode),
         .din   (indata[i*DSIZE +: DSIZE]),
         .dout  (outdata[i*OSIZE +: OSIZE]),
         .sat   (out_sat[i])
      );
   end
   assign out_valid = out_valid_q;
   assign sat_cnt   = cnt_q;
endmodule

// File: tb/tb_sat_round_pipe.sv
// tb_sat_round_pipe: unsigned and signed instances driven in lockstep against an arithmetic reference
module tb_sat_round_pipe;
   logic clock = 1'b0, rst_n = 1'b0, in_valid = 1'b0, rnd_mode = 1'b0, out_ready = 1'b0, cnt_clr = 1'b0;
   logic [31:0] indata = '0;
   logic u_rdy, s_rdy, u_ov, s_ov;
   logic [15:0] u_od, s_od, u_cnt, cu;
   logic [1:0] u_sat, s_sat, s_cnt, cs;
   typedef struct { logic [15:0] uo, so; logic [1:0] us, ss; } beat_t;
   beat_t q[$];
   int checks = 0, failures = 0;
   bit stall_prev = 0, acc;

   always #5 clock = ~clock;

   sat_round_pipe #(.SIGNED(0), .CNT_W(16)) dut_u (
      .clock(clock), .rst_n(rst_n), .in_valid(in_valid), .in_ready(u_rdy), .indata(indata),
      .rnd_mode(rnd_mode), .out_valid(u_ov), .out_ready(out_ready), .outdata(u_od),
      .out_sat(u_sat), .sat_cnt(u_cnt), .cnt_clr(cnt_clr));
   sat_round_pipe #(.SIGNED(1), .CNT_W(2)) dut_s (
      .clock(clock), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_rdy), .indata(indata),
      .rnd_mode(rnd_mode), .out_valid(s_ov), .out_ready(out_ready), .outdata(s_od),
      .out_sat(s_sat), .sat_cnt(s_cnt), .cnt_clr(cnt_clr));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // requantize one 16-bit sample to 8 bits with 4 dropped bits; returns {sat, value}
   function automatic logic [8:0] ref_q(input logic [15:0] x, input bit r, input bit sg);
      int v, hi, lo;
      v  = sg ? int'($signed(x)) : int'({16'h0, x});
      v  = (v + (r ? 8 : 0)) >>> 4;
      hi = sg ? 127 : 255;
      lo = sg ? -128 : 0;
      if (v > hi) return {1'b1, 8'(hi)};
      if (v < lo) return {1'b1, 8'(lo)};
      return {1'b0, 8'(v)};
   endfunction

   function automatic logic [15:0] rnd16();
      case ($urandom_range(0, 2))
         0: return 16'($urandom);
         1: return 16'($urandom_range(0, 4095));
         default: return 16'($urandom_range(61440, 65535));
      endcase
   endfunction

   task automatic step(input bit v, input logic [31:0] d, input bit r, input bit ordy, input bit clr, output bit ok);
      beat_t b;
      logic [8:0] a0, a1, c0, c1;
      bit exp_rdy;
      @(posedge clock); #1;
      in_valid = v; indata = d; rnd_mode = r; out_ready = ordy; cnt_clr = clr;
      #1;
      exp_rdy = !(q.size() == 2 && !ordy);
      check("cnt_u", u_cnt, cu);
      check("cnt_s", s_cnt, cs);
      check("in_ready_u", u_rdy, exp_rdy);
      check("in_ready_s", s_rdy, exp_rdy);
      if (q.size() == 0) begin
         check("ov_idle_u", u_ov, 0);
         check("ov_idle_s", s_ov, 0);
      end
      if (q.size() == 2 || stall_prev) begin
         check("ov_held_u", u_ov, 1);
         check("ov_held_s", s_ov, 1);
      end
      if (u_ov && q.size() > 0) begin
         check("data_u", u_od, q[0].uo);
         check("sat_u", u_sat, q[0].us);
         check("data_s", s_od, q[0].so);
         check("sat_s", s_sat, q[0].ss);
      end
      if (clr) begin
         cu = 0; cs = 0;
      end else if (u_ov && ordy && q.size() > 0) begin
         if (|q[0].us && cu != 16'hFFFF) cu++;
         if (|q[0].ss && cs != 2'd3) cs++;
      end
      if (u_ov && ordy && q.size() > 0) void'(q.pop_front());
      ok = v && exp_rdy;
      if (ok) begin
         a0 = ref_q(d[15:0], r, 0); a1 = ref_q(d[31:16], r, 0);
         c0 = ref_q(d[15:0], r, 1); c1 = ref_q(d[31:16], r, 1);
         b.uo = {a1[7:0], a0[7:0]}; b.us = {a1[8], a0[8]};
         b.so = {c1[7:0], c0[7:0]}; b.ss = {c1[8], c0[8]};
         q.push_back(b);
      end
      stall_prev = u_ov && !ordy;
   endtask

   logic [15:0] tx [10] = '{16'h0ABC, 16'h1ABC, 16'h0AB8, 16'h0FF7, 16'h0FF8,
                            16'hFFF8, 16'hFFF8, 16'h0800, 16'hF7FF, 16'hF800};
   bit          tr [10] = '{0, 0, 1, 1, 1, 0, 1, 0, 0, 0};
   logic [7:0]  tuo[10] = '{8'hAB, 8'hFF, 8'hAC, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h80, 8'hFF, 8'hFF};
   bit          tus[10] = '{0, 1, 0, 0, 1, 1, 1, 0, 1, 1};
   logic [7:0]  tso[10] = '{8'h7F, 8'h7F, 8'h7F, 8'h7F, 8'h7F, 8'hFF, 8'h00, 8'h7F, 8'h80, 8'h80};
   bit          tss[10] = '{1, 1, 1, 1, 1, 0, 0, 1, 1, 0};
   bit          pat[4]  = '{1, 0, 0, 1};

   initial begin
      int sent;
      cu = 0; cs = 0;
      repeat (2) @(posedge clock);
      #1 rst_n = 1'b1;
      check("rst_ov", u_ov, 0);
      check("rst_od", u_od, 0);
      check("rst_sat", u_sat, 0);
      check("rst_cnt", u_cnt, 0);
      check("rst_rdy", u_rdy, 1);
      check("rst_ov_s", s_ov, 0);
      for (int i = 0; i < 10; i++) begin
         step(1, {rnd16(), tx[i]}, tr[i], 1, 0, acc);
         step(0, 0, 0, 1, 0, acc);
         check("lat1", u_ov, 0);
         step(0, 0, 0, 1, 0, acc);
         check("lat2", u_ov, 1);
         check("vec_u", u_od[7:0], tuo[i]);
         check("vec_us", u_sat[0], tus[i]);
         check("vec_s", s_od[7:0], tso[i]);
         check("vec_ss", s_sat[0], tss[i]);
      end
      step(0, 0, 0, 1, 1, acc);
      for (int i = 0; i < 5; i++) step(1, 32'h1ABC_1ABC, 0, 1, 0, acc);
      repeat (3) step(0, 0, 0, 1, 0, acc);
      check("cnt5_u", u_cnt, 5);
      check("cnt_hold_s", s_cnt, 3);
      step(1, 32'h1ABC_1ABC, 0, 1, 0, acc);
      step(0, 0, 0, 1, 0, acc);
      step(0, 0, 0, 1, 1, acc);
      step(0, 0, 0, 1, 0, acc);
      check("clr_win_u", u_cnt, 0);
      check("clr_win_s", s_cnt, 0);
      sent = 0;
      for (int c = 0; c < 200 && sent < 16; c++) begin
         step(1, {rnd16(), rnd16()}, 1'($urandom), pat[c % 4], 0, acc);
         if (acc) sent++;
      end
      check("bp_sent", sent, 16);
      repeat (4) step(0, 0, 0, 1, 0, acc);
      check("bp_drain", q.size(), 0);
      for (int c = 0; c < 400; c++)
         step($urandom_range(0, 3) != 0, {rnd16(), rnd16()}, 1'($urandom), 1'($urandom),
              $urandom_range(0, 31) == 0, acc);
      repeat (4) step(0, 0, 0, 1, 0, acc);
      step(1, 32'h1ABC_1ABC, 0, 1, 0, acc);
      repeat (3) step(0, 0, 0, 1, 0, acc);
      step(1, {rnd16(), rnd16()}, 0, 0, 0, acc);
      step(1, {rnd16(), rnd16()}, 0, 0, 0, acc);
      @(posedge clock); #1;
      rst_n = 1'b0; in_valid = 1'b0;
      @(posedge clock); #1;
      check("mid_rst_ov_u", u_ov, 0);
      check("mid_rst_ov_s", s_ov, 0);
      check("mid_rst_cnt_u", u_cnt, 0);
      check("mid_rst_cnt_s", s_cnt, 0);
      rst_n = 1'b1;
      q.delete(); cu = 0; cs = 0; stall_prev = 0;
      repeat (6) step(0, 0, 0, 1, 0, acc);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
